// File: rtl/predict_fix.sv
// predict_fix: EX-stage branch resolution and writeback register.
// Compares the resolved control-flow outcome with the fetch-stage
// prediction, issues a one-cycle redirect on a mispredict, and then holds
// flush for FLUSH_CYCLES cycles. Results go to writeback through a
// registered valid/ready slot. Misaligned targets are flagged, not redirected.
module predict_fix #(
   parameter int XLEN         = 32,
   parameter int ADDR_SIZE    = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_valid,
   output logic                 ex_ready,
   input  logic [ADDR_SIZE-1:0] ex_pc,
   input  logic [4:0]           ex_rd,
   input  logic                 ex_rd_en,
   input  logic [XLEN-1:0]      write_back_rd,
   input  logic                 op_jump,
   input  logic                 op_bxx,
   input  logic [ADDR_SIZE-1:0] jump_dest,
   input  logic                 jump_whether_or_not,
   input  logic                 pred_taken,
   input  logic [ADDR_SIZE-1:0] pred_dest,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [4:0]           wb_rd,
   output logic [XLEN-1:0]      wb_data,
   output logic                 wb_rd_en,
   output logic                 wb_misalign,
   output logic                 redirect_valid,
   output logic [ADDR_SIZE-1:0] redirect_pc,
   output logic                 flush,
   output logic [15:0]          branch_cnt,
   output logic [15:0]          mispred_cnt
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   state_t               state_r;
   state_t               state_next_s;
   logic [2:0]           flush_cnt_r;
   logic [2:0]           flush_cnt_next_s;
   logic                 accept_s;
   logic                 ctrl_op_s;
   logic                 mispred_s;
   logic                 misalign_s;
   logic                 redirect_s;
   logic                 wb_valid_next_s;
   logic [ADDR_SIZE-1:0] actual_target_s;

   // In FLUSH everything is swallowed; otherwise accept whenever the slot frees up.
   assign ex_ready = (state_r == ST_FLUSH) | ~wb_valid | wb_ready;

   // Resolve the control op and decide accept / mispredict / redirect.
   always_comb begin
      accept_s        = 1'b0;
      ctrl_op_s       = 1'b0;
      mispred_s       = 1'b0;
      misalign_s      = 1'b0;
      redirect_s      = 1'b0;
      actual_target_s = ex_pc + ADDR_SIZE'(4);
      if (jump_whether_or_not) begin
         actual_target_s = jump_dest;
      end else begin
         actual_target_s = ex_pc + ADDR_SIZE'(4);
      end
      accept_s   = ex_valid & ex_ready & (state_r == ST_RUN);
      ctrl_op_s  = op_jump | op_bxx;
      mispred_s  = ctrl_op_s & ((jump_whether_or_not != pred_taken) |
                                (jump_whether_or_not & (jump_dest != pred_dest)));
      misalign_s = ctrl_op_s & jump_whether_or_not & (jump_dest[1:0] != 2'b00);
      redirect_s = accept_s & mispred_s & ~misalign_s;
   end

   // Writeback slot occupancy: load on accept, drain on handshake, replace without a bubble.
   always_comb begin
      wb_valid_next_s = wb_valid;
      if (accept_s) begin
         wb_valid_next_s = 1'b1;
      end else if (wb_valid & wb_ready) begin
         wb_valid_next_s = 1'b0;
      end else begin
         wb_valid_next_s = wb_valid;
      end
   end

   // RUN/FLUSH next state and flush down-counter.
   always_comb begin
      state_next_s     = state_r;
      flush_cnt_next_s = flush_cnt_r;
      case (state_r)
         ST_RUN: begin
            if (redirect_s) begin
               state_next_s     = ST_FLUSH;
               flush_cnt_next_s = FLUSH_LOAD;
            end else begin
               state_next_s     = ST_RUN;
               flush_cnt_next_s = flush_cnt_r;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_r == 3'd1) begin
               state_next_s     = ST_RUN;
               flush_cnt_next_s = 3'd0;
            end else begin
               state_next_s     = ST_FLUSH;
               flush_cnt_next_s = flush_cnt_r - 3'd1;
            end
         end
         default: begin
            state_next_s     = ST_RUN;
            flush_cnt_next_s = 3'd0;
         end
      endcase
   end

   // State register, counter and registered flush/redirect outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_RUN;
         flush_cnt_r    <= 3'd0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         state_r        <= state_next_s;
         flush_cnt_r    <= flush_cnt_next_s;
         flush          <= (state_next_s == ST_FLUSH);
         redirect_valid <= redirect_s;
         if (redirect_s) begin
            redirect_pc <= actual_target_s;
         end
      end
   end

   // Writeback payload: only an accepted result may change it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid    <= 1'b0;
         wb_rd       <= 5'd0;
         wb_data     <= '0;
         wb_rd_en    <= 1'b0;
         wb_misalign <= 1'b0;
      end else begin
         wb_valid <= wb_valid_next_s;
         if (accept_s) begin
            wb_rd       <= ex_rd;
            wb_data     <= write_back_rd;
            wb_rd_en    <= ex_rd_en & (ex_rd != 5'd0);
            wb_misalign <= misalign_s;
         end
      end
   end

   // Saturating branch and mispredict statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt  <= 16'd0;
         mispred_cnt <= 16'd0;
      end else begin
         if (accept_s & ctrl_op_s & (branch_cnt != 16'hFFFF)) begin
            branch_cnt <= branch_cnt + 16'd1;
         end
         if (accept_s & mispred_s & (mispred_cnt != 16'hFFFF)) begin
            mispred_cnt <= mispred_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_predict_fix.sv
// Testbench for predict_fix: directed scenarios, randomized traffic and
// counter saturation, all checked against a behavioural model.
module tb_predict_fix;

   localparam int FLUSH_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_rd_en;
   logic [31:0] write_back_rd;
   logic        op_jump;
   logic        op_bxx;
   logic [31:0] jump_dest;
   logic        jump_whether_or_not;
   logic        pred_taken;
   logic [31:0] pred_dest;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_rd_en;
   logic        wb_misalign;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [15:0] branch_cnt;
   logic [15:0] mispred_cnt;

   predict_fix #(.XLEN(32), .ADDR_SIZE(32), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_rd_en(ex_rd_en), .write_back_rd(write_back_rd),
      .op_jump(op_jump), .op_bxx(op_bxx), .jump_dest(jump_dest),
      .jump_whether_or_not(jump_whether_or_not),
      .pred_taken(pred_taken), .pred_dest(pred_dest),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_rd_en(wb_rd_en), .wb_misalign(wb_misalign),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit          m_wb_valid;
   bit [4:0]    m_rd;
   bit [31:0]   m_data;
   bit          m_rden;
   bit          m_mal;
   bit          m_redir;
   bit [31:0]   m_rpc;
   int          m_flush_left;
   int          m_bcnt;
   int          m_mcnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wb_valid = 0; m_rd = 0; m_data = 0; m_rden = 0; m_mal = 0;
      m_redir = 0; m_rpc = 0; m_flush_left = 0; m_bcnt = 0; m_mcnt = 0;
   endtask

   task automatic check_outputs(input bit check_rpc_always);
      chk("wb_valid", 64'(wb_valid), 64'(m_wb_valid));
      chk("wb_rd", 64'(wb_rd), 64'(m_rd));
      chk("wb_data", 64'(wb_data), 64'(m_data));
      chk("wb_rd_en", 64'(wb_rd_en), 64'(m_rden));
      chk("wb_misalign", 64'(wb_misalign), 64'(m_mal));
      chk("redirect_valid", 64'(redirect_valid), 64'(m_redir));
      if (m_redir || check_rpc_always) chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
      chk("flush", 64'(flush), 64'(m_flush_left > 0));
      chk("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
      chk("mispred_cnt", 64'(mispred_cnt), 64'(m_mcnt));
   endtask

   task automatic drive(input bit v, input bit [31:0] pc, input bit [4:0] rd, input bit rden,
                        input bit [31:0] data, input bit jmp, input bit bxx, input bit [31:0] dest,
                        input bit tk, input bit ptk, input bit [31:0] pdest, input bit wbr);
      ex_valid = v; ex_pc = pc; ex_rd = rd; ex_rd_en = rden; write_back_rd = data;
      op_jump = jmp; op_bxx = bxx; jump_dest = dest; jump_whether_or_not = tk;
      pred_taken = ptk; pred_dest = pdest; wb_ready = wbr;
   endtask

   // One clock: check ex_ready before the edge, advance the model, check after.
   task automatic cycle();
      bit exp_ready, acc, ctrl, mis, mal, drain;
      bit [31:0] tgt;
      #1;
      exp_ready = (m_flush_left > 0) || !m_wb_valid || wb_ready;
      chk("ex_ready", 64'(ex_ready), 64'(exp_ready));
      acc   = ex_valid && exp_ready && (m_flush_left == 0);
      ctrl  = op_jump || op_bxx;
      tgt   = jump_whether_or_not ? jump_dest : ex_pc + 32'd4;
      mis   = ctrl && ((jump_whether_or_not != pred_taken) ||
                       (jump_whether_or_not && (jump_dest != pred_dest)));
      mal   = ctrl && jump_whether_or_not && (jump_dest[1:0] != 2'b00);
      drain = m_wb_valid && wb_ready;
      @(posedge clk);
      m_redir = 0;
      if (m_flush_left > 0) begin
         m_flush_left--;
      end else if (acc && mis && !mal) begin
         m_flush_left = FLUSH_CYCLES;
         m_redir = 1;
         m_rpc = tgt;
      end
      if (acc) begin
         m_wb_valid = 1; m_rd = ex_rd; m_data = write_back_rd;
         m_rden = ex_rd_en && (ex_rd != 5'd0); m_mal = mal;
      end else if (drain) begin
         m_wb_valid = 0;
      end
      if (acc && ctrl && m_bcnt < 65535) m_bcnt++;
      if (acc && mis && m_mcnt < 65535) m_mcnt++;
      #1;
      check_outputs(1'b0);
   endtask

   task automatic alu(input bit [31:0] pc, input bit [4:0] rd, input bit [31:0] data, input bit wbr);
      drive(1, pc, rd, 1, data, 0, 0, 32'd0, 0, 0, 32'd0, wbr);
   endtask

   initial begin
      // Reset state, checked asynchronously without a clock edge
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      rst = 1'b1;
      model_reset();
      #2;
      check_outputs(1'b1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Plain ALU result to writeback
      alu(32'h100, 5'd5, 32'hDEADBEEF, 1);
      cycle();
      chk("alu_wb_data", 64'(wb_data), 64'h0000_0000_DEAD_BEEF);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle();

      // Branch predicted taken, resolved not-taken; two results arrive in the flush window
      drive(1, 32'h200, 5'd0, 0, 32'h0, 0, 1, 32'h240, 0, 1, 32'h240, 1);
      cycle();
      chk("br_redirect_pc", 64'(redirect_pc), 64'h204);
      alu(32'h204, 5'd7, 32'h1111_1111, 1);
      cycle();
      alu(32'h208, 5'd8, 32'h2222_2222, 1);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle();
      chk("br_mispred_cnt", 64'(mispred_cnt), 64'd1);
      chk("br_branch_cnt", 64'(branch_cnt), 64'd1);

      // jalr to a misaligned target with a correct prediction
      drive(1, 32'h300, 5'd1, 1, 32'h304, 1, 0, 32'h402, 1, 1, 32'h402, 1);
      cycle();
      chk("jalr_misalign", 64'(wb_misalign), 64'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle();

      // Backpressure: pending entry held, then replace with no bubble
      alu(32'h400, 5'd3, 32'hAAAA_0001, 0);
      cycle();
      for (int i = 0; i < 3; i++) begin
         alu(32'h404 + 32'(i * 4), 5'd4, 32'hBBBB_0000 + 32'(i), 0);
         cycle();
      end
      alu(32'h410, 5'd6, 32'hCCCC_0002, 1);
      cycle();
      alu(32'h414, 5'd0, 32'hCCCC_0003, 1);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle();

      // Reset during the first flush cycle
      drive(1, 32'h500, 5'd0, 0, 32'h0, 1, 0, 32'h600, 1, 0, 32'h0, 1);
      cycle();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_outputs(1'b1);
      @(negedge clk);
      rst = 1'b0;
      alu(32'h700, 5'd9, 32'h1234_5678, 1);
      cycle();
      chk("post_reset_accept", 64'(wb_valid), 64'd1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bit [31:0] pc, dest, pdest;
         bit jmp, bxx, tk, ptk;
         pc    = $urandom & 32'hFFFF_FFFC;
         dest  = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) dest[1:0] = 2'($urandom_range(1, 3));
         jmp   = ($urandom_range(0, 3) == 0);
         bxx   = !jmp && ($urandom_range(0, 2) == 0);
         tk    = jmp ? 1'b1 : 1'($urandom);
         ptk   = ($urandom_range(0, 3) == 0) ? !tk : tk;
         pdest = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : dest;
         drive(($urandom_range(0, 3) != 0), pc, 5'($urandom), 1'($urandom), $urandom,
               jmp, bxx, dest, tk, ptk, pdest, ($urandom_range(0, 9) < 7));
         cycle();
      end

      // Drive both counters to saturation with misaligned mispredicts (no flush)
      drive(1, 32'h800, 5'd2, 1, 32'h0, 0, 1, 32'h902, 1, 0, 32'h0, 1);
      for (int i = 0; i < 65540; i++) begin
         cycle();
      end
      chk("sat_mispred_cnt", 64'(mispred_cnt), 64'hFFFF);
      chk("sat_branch_cnt", 64'(branch_cnt), 64'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/predict_fix.md
PREDICT_FIX -- requirements
Module: predict_fix

Interface
REQ-001 Parameter XLEN, default 32, data width.
REQ-002 Parameter ADDR_SIZE, default 32, PC width.
REQ-003 Parameter FLUSH_CYCLES, default 2, range 1..7, number of cycles flush is held after a redirect.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ex_valid  input  1  EX result valid this cycle.
REQ-007 ex_ready  output  1  this block accepts the EX result.
REQ-008 ex_pc  input  ADDR_SIZE  PC of the EX instruction.
REQ-009 ex_rd  input  5  destination register index.
REQ-010 ex_rd_en  input  1  instruction writes rd.
REQ-011 write_back_rd  input  XLEN  EX result data.
REQ-012 op_jump, op_bxx  input  1 each  instruction is a jal/jalr or a conditional branch.
REQ-013 jump_dest  input  ADDR_SIZE  resolved target.
REQ-014 jump_whether_or_not  input  1  resolved taken.
REQ-015 pred_taken, pred_dest  input  1, ADDR_SIZE  fetch-stage prediction carried with the instruction.
REQ-016 wb_valid / wb_ready  output / input  1 each  writeback handshake.
REQ-017 wb_rd, wb_data, wb_rd_en  output  5, XLEN, 1  registered writeback payload.
REQ-018 wb_misalign  output  1  taken target not 4-byte aligned; qualified by wb_valid.
REQ-019 redirect_valid, redirect_pc  output  1, ADDR_SIZE  one-cycle fetch redirect.
REQ-020 flush  output  1  kill younger instructions in IF/ID.
REQ-021 branch_cnt, mispred_cnt  output  16 each  saturating statistics.

Function
REQ-022 ex_ready SHALL equal (state==FLUSH) | ~wb_valid | wb_ready.
REQ-023 Accept = ex_valid & ex_ready & (state==RUN); only accepted results SHALL load the output register, on the next edge.
REQ-024 wb_valid SHALL set on accept, clear when wb_valid & wb_ready and no accept that cycle; accept and drain in the same cycle SHALL replace the entry with no bubble.
REQ-025 wb_rd_en SHALL be loaded as ex_rd_en & (ex_rd!=0); x0 is never written.
REQ-026 Control op = op_jump | op_bxx; actual target = jump_whether_or_not ? jump_dest : ex_pc+4 (modulo 2^ADDR_SIZE).
REQ-027 Mispredict = control op & ((jump_whether_or_not != pred_taken) | (jump_whether_or_not & jump_dest != pred_dest)).
REQ-028 Misaligned = control op & jump_whether_or_not & (jump_dest[1:0] != 0); it SHALL set wb_misalign with the entry and SHALL suppress any redirect for that instruction.
REQ-029 An accepted mispredict that is not misaligned SHALL assert redirect_valid for exactly one cycle after the accepting edge, with redirect_pc = actual target. The block SHALL then enter FLUSH.
REQ-030 States: RUN and FLUSH. RUN->FLUSH on REQ-029, loading a 3-bit counter with FLUSH_CYCLES. In FLUSH, flush=1 and the counter decrements each cycle. FLUSH->RUN on the edge where the counter equals 1, so flush is high for exactly FLUSH_CYCLES cycles.
REQ-031 In FLUSH, ex_valid results SHALL be consumed (ex_ready=1) and discarded: no wb load, no redirect, no counter update.
REQ-032 branch_cnt SHALL increment on each accepted control op. mispred_cnt SHALL increment on each accepted mispredict, including misaligned ones. Both SHALL saturate at 16'hFFFF.
REQ-033 A pending wb entry SHALL be held stable while wb_valid & ~wb_ready, including across FLUSH.

Reset
REQ-034 While rst=1, regardless of clk: state=RUN, flush counter=0, wb_valid=0, wb_rd=0, wb_data=0, wb_rd_en=0, wb_misalign=0, redirect_valid=0, redirect_pc=0, flush=0, branch_cnt=0, mispred_cnt=0.
REQ-035 Reset asserted mid-FLUSH or with a pending wb entry SHALL abandon both; the first cycle after deassertion SHALL be RUN with ex_ready=1.

Verification
REQ-036 ALU op at ex_pc=0x100, rd=5, data=0xDEADBEEF, wb_ready=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF, no redirect, counters unchanged.
REQ-037 Branch at ex_pc=0x200, pred_taken=1, pred_dest=0x240, resolved not-taken -> redirect_valid one cycle with redirect_pc=0x204; flush high 2 cycles; two ex_valid results in that window discarded; mispred_cnt=1, branch_cnt=1.
REQ-038 jalr at 0x300, rd=1, resolved taken to 0x402, prediction matched -> wb_misalign=1, wb_data=0x304, no redirect, flush stays 0.
REQ-039 wb_ready=0 for 3 cycles with ex_valid=1 -> ex_ready=0, entry stable. Then wb_ready=1 with new ex_valid -> back-to-back transfer, no bubble.
REQ-040 rst pulsed during the first flush cycle -> all outputs 0 immediately (asynchronously). After release, an ALU op is accepted in the first cycle.
REQ-041 Force mispred_cnt=0xFFFF, then one more mispredict -> mispred_cnt stays 0xFFFF and branch_cnt increments.
